picorv32_mem_arbiter: RTL and testbench

PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

---
 rtl/picorv32_mc_pkg.sv | 16 +
 rtl/mc_rr_picker.sv | 30 +++
 rtl/picorv32_mem_arbiter.sv | 113 +++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_mc_pkg.sv
// picorv32_mc_pkg: shared FSM type, id-width helper and default error read data
package picorv32_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mc_rr_picker.sv
// mc_rr_picker: combinational winner selection, round-robin after last or lowest index first
module mc_rr_picker
    import picorv32_mc_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    input  logic           mode,
    output logic [IDW-1:0] winner,
    output logic           valid
);

    // scan from last+1 in round-robin mode or from 0 in fixed mode; first asserted request wins
    always_comb begin
        int k;
        winner = '0;
        valid  = 1'b0;
        k      = 0;
        for (int i = 0; i < N; i++) begin
            k = mode ? i : (int'(last) + 1 + i) % N;
            if (!valid && req[k]) begin
                winner = IDW'(k);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: shares one picorv32-style memory port between N cores with a wait timeout
module picorv32_mem_arbiter
    import picorv32_mc_pkg::*;
#(
    parameter int          N         = 2,
    parameter int          PRIO_MODE = 0,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT,
    localparam int         IDW       = idw(N)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         core_valid,
    input  logic [N-1:0]         core_instr,
    input  logic [N-1:0][31:0]   core_addr,
    input  logic [N-1:0][31:0]   core_wdata,
    input  logic [N-1:0][3:0]    core_wstrb,
    output logic [N-1:0]         core_ready,
    output logic [N-1:0][31:0]   core_rdata,
    output logic                 mem_valid,
    output logic                 mem_instr,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 err_pulse
);

    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t         state, state_nx;
    logic [IDW-1:0] last, winner;
    logic           found;
    logic [CW-1:0]  wait_cnt;
    logic           expired;

    mc_rr_picker #(.N(N), .IDW(IDW)) u_picker (
        .req    (core_valid),
        .last   (last),
        .mode   (PRIO_MODE != 0),
        .winner (winner),
        .valid  (found)
    );

    assign expired = (TIMEOUT > 0) && (wait_cnt == CW'(TLIM));
    assign busy    = state != IDLE;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // next state: arbitrate only in IDLE, leave REQ on data or timeout, RESP lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? REQ : IDLE;
            REQ:     state_nx = (mem_ready || expired) ? RESP : REQ;
            default: state_nx = IDLE;
        endcase
    end

    // completion pulse goes only to the granted core while in RESP
    always_comb begin
        core_ready = '0;
        if (state == RESP) core_ready[grant_id] = 1'b1;
    end

    // request latch on grant, wait counting, and response capture on data or timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid  <= 1'b0;
            mem_instr  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            core_rdata <= '0;
            grant_id   <= '0;
            last       <= IDW'(N - 1);
            wait_cnt   <= '0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (state == IDLE && found) begin
                mem_valid <= 1'b1;
                mem_instr <= core_instr[winner];
                mem_addr  <= core_addr[winner];
                mem_wdata <= core_wdata[winner];
                mem_wstrb <= core_wstrb[winner];
                grant_id  <= winner;
                last      <= winner;
                wait_cnt  <= '0;
            end else if (state == REQ) begin
                if (mem_ready) begin
                    mem_valid            <= 1'b0;
                    core_rdata[grant_id] <= mem_rdata;
                end else if (expired) begin
                    mem_valid            <= 1'b0;
                    core_rdata[grant_id] <= ERR_RDATA;
                    err_pulse            <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: randomized scoreboard bench for the shared memory arbiter
module tb_picorv32_mem_arbiter;

    localparam int          N    = 4;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]       core_valid, core_instr, core_ready;
    logic [N-1:0][31:0] core_addr, core_wdata, core_rdata;
    logic [N-1:0][3:0]  core_wstrb;
    logic               mem_valid, mem_instr, mem_ready, busy, err_pulse;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic [3:0]         mem_wstrb;
    logic [1:0]         grant_id;

    logic               p_resetn = 1'b1;
    logic [N-1:0]       p_core_valid, p_core_instr, p_core_ready;
    logic [N-1:0][31:0] p_core_addr, p_core_wdata, p_core_rdata;
    logic [N-1:0][3:0]  p_core_wstrb;
    logic               p_mem_valid, p_mem_instr, p_mem_ready, p_busy, p_err_pulse;
    logic [31:0]        p_mem_addr, p_mem_wdata, p_mem_rdata;
    logic [3:0]         p_mem_wstrb;
    logic [1:0]         p_grant_id;

    picorv32_mem_arbiter #(.N(N), .PRIO_MODE(0), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .core_valid(core_valid), .core_instr(core_instr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_ready(core_ready),
        .core_rdata(core_rdata), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .grant_id(grant_id),
        .busy(busy), .err_pulse(err_pulse)
    );

    picorv32_mem_arbiter #(.N(N), .PRIO_MODE(1), .TIMEOUT(0)) dut_p (
        .clk(clk), .resetn(p_resetn),
        .core_valid(p_core_valid), .core_instr(p_core_instr), .core_addr(p_core_addr),
        .core_wdata(p_core_wdata), .core_wstrb(p_core_wstrb), .core_ready(p_core_ready),
        .core_rdata(p_core_rdata), .mem_valid(p_mem_valid), .mem_instr(p_mem_instr),
        .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_wstrb(p_mem_wstrb),
        .mem_ready(p_mem_ready), .mem_rdata(p_mem_rdata), .grant_id(p_grant_id),
        .busy(p_busy), .err_pulse(p_err_pulse)
    );

    int npass = 0, ntot = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb[$];
    int          grants[$];
    int          cst[N];
    logic [31:0] r_addr[N], r_wdata[N], model_rd[N];
    logic [3:0]  r_wstrb[N];
    logic        r_instr[N];
    int          m_last = N - 1;
    int          gen_pct = 0, force_wait = -1, k = 0, wt = 0, ngrant = 0, nresp = 0;
    bit          drop_en = 0, prev_mv = 0, prio_done = 0;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb;
    logic        g_instr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h1234_5778;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int s = 1; s <= N; s++) if (v[(last + s) % N]) return (last + s) % N;
        return -1;
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins);
        r_addr[i] = a; r_wdata[i] = d; r_wstrb[i] = s; r_instr[i] = ins;
        core_addr[i] = a; core_wdata[i] = d; core_wstrb[i] = s; core_instr[i] = ins;
        core_valid[i] = 1'b1;
        cst[i] = 1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_core_ready", core_ready, 0);
        chk("rst_core_rdata_nonzero", core_rdata != '0, 0);
        chk("rst_mem_fields", {mem_instr, mem_wstrb, mem_addr, mem_wdata != 0}, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy_err", {busy, err_pulse}, 0);
        sb.delete();
        m_last = N - 1;
        core_valid = '0;
        mem_ready = 1'b0;
        prev_mv = 0; k = 0; ngrant = 0; nresp = 0;
        for (int i = 0; i < N; i++) begin cst[i] = 0; model_rd[i] = '0; end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // one negedge of core and memory behaviour; the model predicts grants and queues expected responses
    task automatic drv_step();
        logic [N-1:0] vsnap;
        int pred, gid;
        vsnap = core_valid;
        for (int i = 0; i < N; i++) if (cst[i] == 2) begin core_valid[i] = 1'b0; cst[i] = 0; end
        for (int i = 0; i < N; i++) if (core_ready[i]) cst[i] = 2;
        if (mem_valid && !prev_mv) begin
            gid  = int'(grant_id);
            pred = rr_pick(vsnap, m_last);
            chk("grant_id", grant_id, pred);
            chk("grant_to_pending", cst[gid], 1);
            m_last = (pred >= 0) ? pred : gid;
            g_addr = r_addr[gid]; g_wdata = r_wdata[gid]; g_wstrb = r_wstrb[gid]; g_instr = r_instr[gid];
            wt = (force_wait >= 0) ? force_wait
               : ($urandom_range(0, 11) > 9 ? 99 : int'($urandom_range(0, 9)));
            sb.push_back('{gid, (wt < TO) ? mem_fn(g_addr) : ERRD, wt >= TO,
                           cyc + ((wt < TO) ? wt : TO - 1) + 1});
            k = 0;
            ngrant++;
            grants.push_back(gid);
            if (drop_en && $urandom_range(0, 3) == 0) begin
                core_valid[gid] = 1'b0;
                core_addr[gid]  = $urandom;
            end
        end else if (mem_valid) k++;
        if (mem_valid) begin
            chk("mem_addr", mem_addr, g_addr);
            chk("mem_ctl_wdata", {mem_instr, mem_wstrb, mem_wdata}, {g_instr, g_wstrb, g_wdata});
            mem_ready = (k == wt);
            mem_rdata = mem_ready ? mem_fn(g_addr) : $urandom;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
        prev_mv = mem_valid;
        for (int i = 0; i < N; i++)
            if (cst[i] == 0 && $urandom_range(0, 99) < gen_pct)
                issue(i, $urandom & 32'hFFFF_FFFC, $urandom,
                      $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0, 1'($urandom_range(0, 1)));
    endtask

    task automatic run(input int n);
        repeat (n) begin @(negedge clk); drv_step(); end
    endtask

    // monitor: every completion pulse pops the oldest expectation and checks it
    exp_t       me;
    logic [N-1:0] oh;
    always @(negedge clk) if (resetn) begin
        chk("busy", busy, mem_valid || (core_ready != '0));
        if (err_pulse && core_ready == '0) chk("err_without_ready", err_pulse, 0);
        if (core_ready != '0) begin
            if (sb.size() == 0) chk("unexpected_core_ready", core_ready, 0);
            else begin
                me = sb.pop_front();
                oh = '0;
                oh[me.id] = 1'b1;
                chk("ready_onehot", core_ready, oh);
                chk("resp_cycle", cyc, me.cyc);
                chk("err_pulse", err_pulse, me.err);
                model_rd[me.id] = me.rdata;
                for (int i = 0; i < N; i++) chk($sformatf("core_rdata%0d", i), core_rdata[i], model_rd[i]);
                nresp++;
            end
        end
    end

    // fixed-priority instance: cores 1 and 3 always request, core 1 must always win
    initial begin
        int pg, bad;
        bit pmv;
        pg = 0; bad = 0; pmv = 0;
        p_core_valid = '0; p_core_instr = '0; p_core_wdata = '0; p_core_wstrb = '0; p_core_addr = '0;
        p_mem_ready = 1'b0; p_mem_rdata = '0;
        #1 p_resetn = 1'b0;
        repeat (2) @(negedge clk);
        p_resetn = 1'b1;
        p_core_addr[1] = 32'h40; p_core_addr[3] = 32'h80;
        p_core_valid = 4'b1010;
        repeat (60) begin
            @(negedge clk);
            if (p_mem_valid && !pmv) begin pg++; chk("prio_grant", p_grant_id, 1); end
            if (p_core_ready != '0) begin
                chk("prio_ready", p_core_ready, 4'b0010);
                chk("prio_rdata", p_core_rdata[1], mem_fn(32'h40));
            end
            pmv = p_mem_valid;
            p_mem_ready = p_mem_valid;
            p_mem_rdata = mem_fn(p_mem_addr);
        end
        chk("prio_grant_count", pg >= 15, 1);
        p_mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        repeat (40) begin
            @(negedge clk);
            if (p_core_ready != '0 || p_err_pulse) bad++;
        end
        chk("no_timeout_when_disabled", bad, 0);
        chk("no_timeout_still_waiting", {p_mem_valid, p_busy}, 2'b11);
        prio_done = 1;
    end

    initial begin
        int c0, got, seen;
        bit hit;
        core_valid = '0; core_instr = '0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < N; i++) begin cst[i] = 0; model_rd[i] = '0; end
        #1 do_reset();

        @(negedge clk); drv_step();
        force_wait = 0;
        issue(0, 32'h100, 32'h0, 4'h0, 1'b0);
        c0 = cyc; got = -1;
        for (int t = 0; t < 10 && got < 0; t++) begin
            @(negedge clk); drv_step();
            if (core_ready[0]) begin got = cyc; chk("first_read_rdata", core_rdata[0], 32'h1234_5678); end
        end
        chk("first_read_latency", got - c0, 2);
        run(5);

        @(negedge clk); do_reset();
        grants.delete();
        force_wait = -1; gen_pct = 100;
        for (int t = 0; t < 120 && grants.size() < 5; t++) run(1);
        gen_pct = 0;
        chk("rr_order", grants.size() >= 5 ? {grants[0][3:0], grants[1][3:0], grants[2][3:0],
                                              grants[3][3:0], grants[4][3:0]} : 20'hFFFFF, 20'h01230);
        run(80);

        drop_en = 1; gen_pct = 30;
        run(2500);
        drop_en = 0; gen_pct = 0;
        run(200);
        chk("drain_scoreboard_empty", sb.size(), 0);
        chk("drain_resp_eq_grants", nresp, ngrant);
        seen = 0;
        for (int i = 0; i < N; i++) if (cst[i] != 0) seen++;
        chk("drain_no_pending", seen, 0);

        force_wait = 99;
        @(negedge clk); drv_step();
        issue(2, 32'h2000, 32'h55AA_55AA, 4'hF, 1'b0);
        hit = 0;
        for (int t = 0; t < 20 && !hit; t++) begin
            @(negedge clk); drv_step();
            hit = mem_valid && k == 2;
        end
        chk("reached_req_before_reset", hit, 1);
        do_reset();
        seen = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk); drv_step();
            if (core_ready != '0) seen++;
        end
        chk("no_ready_after_reset", seen, 0);
        force_wait = 0; gen_pct = 100;
        grants.delete();
        for (int t = 0; t < 10 && grants.size() == 0; t++) run(1);
        chk("grant_after_reset", grants.size() > 0 ? grants[0] : -1, 0);
        gen_pct = 0;
        run(60);
        chk("final_scoreboard_empty", sb.size(), 0);

        for (int t = 0; t < 300 && !prio_done; t++) @(negedge clk);
        chk("prio_sequence_done", prio_done, 1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
